// File: rtl/usb_bit_engine_pkg.sv
// Shared constants for the USB full-speed bit engine: CRC polynomials,
// init/residue values and the bit-stuffing run length.
package usb_bit_engine_pkg;

   localparam logic [4:0]  CRC5_POLY     = 5'h05;
   localparam logic [4:0]  CRC5_INIT     = 5'h1F;
   localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
   localparam logic [15:0] CRC16_POLY    = 16'h8005;
   localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUE = 16'h800D;
   localparam int          MAX_ONES      = 6;
   localparam int          ONES_W        = 3;
   localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(MAX_ONES);

   // Transmit order is LSB first, so the register is bit-reversed and inverted.
   function automatic logic [15:0] crcOut(input logic [15:0] r, input logic use16);
      logic [15:0] o;
      o = '0;
      if (use16) begin
         for (int i = 0; i < 16; i++) o[i] = ~r[15-i];
      end else begin
         for (int i = 0; i < 5; i++) o[i] = ~r[4-i];
      end
      return o;
   endfunction

endpackage

// File: rtl/usb_bit_engine_if.sv
// Signal bundle between the SIE and the bit engine; slave is the engine side.
interface usb_bit_engine_if;

   logic        dpplClear_i;
   logic        dpPosEdgeSync_i;
   logic        dpNegEdgeSync_i;
   logic        readCLK12_o;
   logic        bitStrobe_o;
   logic        DPPLGotSignal_o;
   logic        crcReset_i;
   logic        crcValid_i;
   logic        useCRC16_i;
   logic        crcData_i;
   logic        validCRC_o;
   logic [15:0] crc_o;
   logic        bitStuffRst_i;
   logic        isSendingPhase_i;
   logic        bitStuffData_i;
   logic        bitStuffReadyValid_o;
   logic        bitStuffData_o;
   logic        bitStuffError_o;

   modport master (
      output dpplClear_i, dpPosEdgeSync_i, dpNegEdgeSync_i,
             crcReset_i, crcValid_i, useCRC16_i, crcData_i,
             bitStuffRst_i, isSendingPhase_i, bitStuffData_i,
      input  readCLK12_o, bitStrobe_o, DPPLGotSignal_o, validCRC_o, crc_o,
             bitStuffReadyValid_o, bitStuffData_o, bitStuffError_o
   );

   modport slave (
      input  dpplClear_i, dpPosEdgeSync_i, dpNegEdgeSync_i,
             crcReset_i, crcValid_i, useCRC16_i, crcData_i,
             bitStuffRst_i, isSendingPhase_i, bitStuffData_i,
      output readCLK12_o, bitStrobe_o, DPPLGotSignal_o, validCRC_o, crc_o,
             bitStuffReadyValid_o, bitStuffData_o, bitStuffError_o
   );

endinterface

// File: rtl/usb_bit_clk_recovery.sv
// 4x oversampling DPLL: a 2-bit phase counter re-aligned by every D+ edge,
// giving the 12 MHz bit clock and a mid-bit strobe.
module usb_bit_clk_recovery (
   input  logic clk48_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic posEdge_i,
   input  logic negEdge_i,
   output logic readCLK12_o,
   output logic bitStrobe_o,
   output logic gotSignal_o
);

   logic [1:0] phase;
   logic       anyEdge;

   assign anyEdge = posEdge_i | negEdge_i;

   always_ff @(posedge clk48_i or negedge rst_ni) begin
      if (!rst_ni)                 phase <= 2'd0;
      else if (clear_i || anyEdge) phase <= 2'd0;
      else                         phase <= phase + 2'd1;
   end

   // An edge coincident with a clear still counts as signal present.
   always_ff @(posedge clk48_i or negedge rst_ni) begin
      if (!rst_ni)      gotSignal_o <= 1'b0;
      else if (clear_i) gotSignal_o <= anyEdge;
      else if (anyEdge) gotSignal_o <= 1'b1;
   end

   assign bitStrobe_o = (phase == 2'd2);
   assign readCLK12_o = phase[1];

endmodule

// File: rtl/usb_bit_engine.sv
// USB FS bit engine: DPLL bit timing, serial CRC5/CRC16 and bit (un)stuffing,
// with CRC and stuffing advancing only on the recovered bit strobe.
module usb_bit_engine
   import usb_bit_engine_pkg::*;
(
   input  logic            clk48_i,
   input  logic            rst_ni,
   usb_bit_engine_if.slave bus
);

   logic              bitStrobe;
   logic              readClk12;
   logic              gotSignal;
   logic [15:0]       crcReg;
   logic [15:0]       crcNext;
   logic              fb;
   logic [ONES_W-1:0] onesCnt;
   logic              stuffErr;
   logic              stuffSlot;

   usb_bit_clk_recovery u_clkRec (
      .clk48_i     (clk48_i),
      .rst_ni      (rst_ni),
      .clear_i     (bus.dpplClear_i),
      .posEdge_i   (bus.dpPosEdgeSync_i),
      .negEdge_i   (bus.dpNegEdgeSync_i),
      .readCLK12_o (readClk12),
      .bitStrobe_o (bitStrobe),
      .gotSignal_o (gotSignal)
   );

   assign bus.bitStrobe_o     = bitStrobe;
   assign bus.readCLK12_o     = readClk12;
   assign bus.DPPLGotSignal_o = gotSignal;

   // CRC5 mode only touches the low five bits; the rest keep their value.
   always_comb begin
      crcNext = crcReg;
      fb      = 1'b0;
      if (bus.useCRC16_i) begin
         fb      = bus.crcData_i ^ crcReg[15];
         crcNext = {crcReg[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end else begin
         fb           = bus.crcData_i ^ crcReg[4];
         crcNext[4:0] = {crcReg[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
      end
   end

   always_ff @(posedge clk48_i or negedge rst_ni) begin
      if (!rst_ni)                         crcReg <= CRC16_INIT;
      else if (bus.crcReset_i)             crcReg <= CRC16_INIT;
      else if (bitStrobe && bus.crcValid_i) crcReg <= crcNext;
   end

   assign bus.validCRC_o = bus.useCRC16_i ? (crcReg == CRC16_RESIDUE)
                                          : (crcReg[4:0] == CRC5_RESIDUE);
   assign bus.crc_o      = crcOut(crcReg, bus.useCRC16_i);

   assign stuffSlot = (onesCnt == ONES_MAX);

   // The slot after six ones is the stuff bit: inserted on TX, dropped on RX.
   always_ff @(posedge clk48_i or negedge rst_ni) begin
      if (!rst_ni) begin
         onesCnt  <= '0;
         stuffErr <= 1'b0;
      end else if (bus.bitStuffRst_i) begin
         onesCnt  <= '0;
         stuffErr <= 1'b0;
      end else if (bitStrobe) begin
         if (stuffSlot) begin
            onesCnt <= '0;
            if (!bus.isSendingPhase_i && bus.bitStuffData_i) stuffErr <= 1'b1;
         end else if (bus.bitStuffData_i) begin
            onesCnt <= onesCnt + 1'b1;
         end else begin
            onesCnt <= '0;
         end
      end
   end

   assign bus.bitStuffReadyValid_o = ~stuffSlot;
   assign bus.bitStuffData_o       = stuffSlot ? 1'b0 : bus.bitStuffData_i;
   assign bus.bitStuffError_o      = stuffErr;

endmodule

// File: tb/tb_usb_bit_engine.sv
// Bench for usb_bit_engine: timestamp/queue based reference model checked on
// every cycle, directed sequences with literal expectations, then random traffic.
module tb_usb_bit_engine;

   logic clk48_i;
   logic rst_ni;
   usb_bit_engine_if bus ();

   usb_bit_engine dut (.clk48_i(clk48_i), .rst_ni(rst_ni), .bus(bus));

   int checks   = 0;
   int failures = 0;

   initial clk48_i = 1'b0;
   always #10 clk48_i = ~clk48_i;

   initial begin
      #10000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int cyc       = 0;
   int lastAlign = 0;
   bit gotSig    = 0;
   bit crcBits[$];
   bit hist[$];
   bit stuffErr  = 0;

   function automatic bit mStrobe();
      return ((cyc - lastAlign) % 4) == 2;
   endfunction

   function automatic bit mClk12();
      return ((cyc - lastAlign) % 4) >= 2;
   endfunction

   function automatic bit mSlot();
      int n;
      n = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i]) n++;
         else break;
      end
      return n >= 6;
   endfunction

   function automatic logic [15:0] mCrc(input bit m16);
      logic [15:0] r;
      bit          f;
      r = 16'hFFFF;
      foreach (crcBits[i]) begin
         if (m16) begin
            f = crcBits[i] ^ r[15];
            r = {r[14:0], 1'b0} ^ (f ? 16'h8005 : 16'h0000);
         end else begin
            f = crcBits[i] ^ r[4];
            r[4:0] = {r[3:0], 1'b0} ^ (f ? 5'h05 : 5'h00);
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] expCrcOut(input logic [15:0] r, input bit m16);
      logic [15:0] o;
      int          w;
      o = '0;
      w = m16 ? 16 : 5;
      for (int i = 0; i < w; i++) o[i] = ~r[w-1-i];
      return o;
   endfunction

   always @(posedge clk48_i) begin
      bit s;
      bit e;
      s = mStrobe();
      cyc++;
      if (!rst_ni) begin
         lastAlign = cyc;
         gotSig    = 0;
         crcBits.delete();
         hist.delete();
         stuffErr  = 0;
      end else begin
         e = bus.dpPosEdgeSync_i | bus.dpNegEdgeSync_i;
         if (bus.dpplClear_i || e) lastAlign = cyc;
         if (bus.dpplClear_i) gotSig = e;
         else if (e)          gotSig = 1;
         if (bus.crcReset_i) crcBits.delete();
         else if (s && bus.crcValid_i) crcBits.push_back(bus.crcData_i);
         if (bus.bitStuffRst_i) begin
            hist.delete();
            stuffErr = 0;
         end else if (s) begin
            if (mSlot()) begin
               if (!bus.isSendingPhase_i && bus.bitStuffData_i) stuffErr = 1;
               hist.delete();
            end else begin
               hist.push_back(bus.bitStuffData_i);
            end
         end
      end
   end

   always @(negedge clk48_i) begin
      logic [15:0] r;
      bit          slot;
      if (!rst_ni) begin
         chk("rstStrobe", bus.bitStrobe_o, 0);
         chk("rstClk12", bus.readCLK12_o, 0);
         chk("rstGot", bus.DPPLGotSignal_o, 0);
         chk("rstCrc", bus.crc_o, 0);
         chk("rstErr", bus.bitStuffError_o, 0);
      end else begin
         r    = mCrc(bus.useCRC16_i);
         slot = mSlot();
         chk("strobe", bus.bitStrobe_o, mStrobe());
         chk("clk12", bus.readCLK12_o, mClk12());
         chk("gotSignal", bus.DPPLGotSignal_o, gotSig);
         chk("crcOut", bus.crc_o, expCrcOut(r, bus.useCRC16_i));
         chk("validCrc", bus.validCRC_o,
             bus.useCRC16_i ? (r == 16'h800D) : (r[4:0] == 5'b01100));
         chk("stuffRv", bus.bitStuffReadyValid_o, !slot);
         if (bus.isSendingPhase_i)
            chk("stuffOut", bus.bitStuffData_o, slot ? 1'b0 : bus.bitStuffData_i);
         chk("stuffErr", bus.bitStuffError_o, stuffErr);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk48_i);
      #1;
   endtask

   task automatic waitStrobe();
      int n;
      n = 0;
      while (!bus.bitStrobe_o && n < 8) begin
         tick();
         n++;
      end
      chk("strobeWait", n < 8, 1);
   endtask

   task automatic sendCrcBit(input bit b);
      bus.crcData_i  = b;
      bus.crcValid_i = 1'b1;
      waitStrobe();
      tick();
      bus.crcValid_i = 1'b0;
   endtask

   task automatic crcMode(input bit m16);
      bus.crcReset_i = 1'b1;
      tick();
      bus.useCRC16_i = m16;
      tick();
      bus.crcReset_i = 1'b0;
   endtask

   task automatic pulseEdge(input bit pol);
      if (pol) bus.dpPosEdgeSync_i = 1'b1;
      else     bus.dpNegEdgeSync_i = 1'b1;
      tick();
      bus.dpPosEdgeSync_i = 1'b0;
      bus.dpNegEdgeSync_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("edgeStrobe", bus.bitStrobe_o, k == 2);
         if (k < 3) tick();
      end
      chk("edgeGot", bus.DPPLGotSignal_o, 1);
   endtask

   task automatic stuffStep(input bit b, input bit expRv, input bit expOut);
      bus.bitStuffData_i = b;
      waitStrobe();
      chk("stepRv", bus.bitStuffReadyValid_o, expRv);
      if (bus.isSendingPhase_i) chk("stepOut", bus.bitStuffData_o, expOut);
      tick();
   endtask

   task automatic stuffReset();
      bus.bitStuffRst_i = 1'b1;
      tick();
      bus.bitStuffRst_i = 1'b0;
   endtask

   initial begin
      logic [15:0] e;
      logic [7:0]  byteV;
      bit          pendMode;
      rst_ni               = 1'b0;
      bus.dpplClear_i      = 1'b0;
      bus.dpPosEdgeSync_i  = 1'b0;
      bus.dpNegEdgeSync_i  = 1'b0;
      bus.crcReset_i       = 1'b0;
      bus.crcValid_i       = 1'b0;
      bus.useCRC16_i       = 1'b1;
      bus.crcData_i        = 1'b0;
      bus.bitStuffRst_i    = 1'b0;
      bus.isSendingPhase_i = 1'b1;
      bus.bitStuffData_i   = 1'b0;
      repeat (3) tick();
      rst_ni = 1'b1;
      tick();

      // DPLL: edges every 4 cycles, then one shifted by a cycle, then clear
      chk("gotBeforeEdge", bus.DPPLGotSignal_o, 0);
      pulseEdge(1);
      pulseEdge(0);
      pulseEdge(1);
      tick();
      pulseEdge(0);
      bus.dpplClear_i = 1'b1;
      tick();
      bus.dpplClear_i = 1'b0;
      chk("clearGot", bus.DPPLGotSignal_o, 0);

      // CRC16 over 00 01 02 03 followed by its own CRC
      crcMode(1);
      chk("crc16Init", bus.crc_o, 16'h0000);
      for (int by = 0; by < 4; by++) begin
         byteV = 8'(by);
         for (int i = 0; i < 8; i++) sendCrcBit(byteV[i]);
      end
      e = expCrcOut(mCrc(1), 1);
      chk("crc16Value", bus.crc_o, e);
      for (int i = 0; i < 16; i++) sendCrcBit(e[i]);
      chk("crc16Good", bus.validCRC_o, 1);

      crcMode(1);
      for (int by = 0; by < 4; by++) begin
         byteV = 8'(by);
         if (by == 2) byteV[5] = ~byteV[5];
         for (int i = 0; i < 8; i++) sendCrcBit(byteV[i]);
      end
      for (int i = 0; i < 16; i++) sendCrcBit(e[i]);
      chk("crc16Bad", bus.validCRC_o, 0);

      // CRC5 over an all-ones token
      crcMode(0);
      chk("crc5Init", bus.crc_o, 16'h0000);
      for (int i = 0; i < 11; i++) sendCrcBit(1'b1);
      e = expCrcOut(mCrc(0), 0);
      chk("crc5Upper", e[15:5], 11'h0);
      for (int i = 0; i < 5; i++) sendCrcBit(e[i]);
      chk("crc5Good", bus.validCRC_o, 1);

      // TX stuffing: 1111111 -> 1111110 1
      bus.isSendingPhase_i = 1'b1;
      stuffReset();
      for (int i = 0; i < 6; i++) stuffStep(1, 1, 1);
      stuffStep(1, 0, 0);
      stuffStep(1, 1, 1);
      stuffStep(0, 1, 0);

      // RX unstuffing: good stuff bit, then a violation
      bus.isSendingPhase_i = 1'b0;
      stuffReset();
      for (int i = 0; i < 6; i++) stuffStep(1, 1, 1);
      stuffStep(0, 0, 0);
      chk("rxNoErr", bus.bitStuffError_o, 0);
      for (int i = 0; i < 6; i++) stuffStep(1, 1, 1);
      stuffStep(1, 0, 0);
      chk("rxErr", bus.bitStuffError_o, 1);
      stuffStep(0, 1, 0);
      stuffStep(1, 1, 1);
      chk("rxErrSticky", bus.bitStuffError_o, 1);
      stuffReset();
      chk("rxErrCleared", bus.bitStuffError_o, 0);

      // random traffic against the model
      pendMode = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) rst_ni = 1'b0;
         if (i == 2003) rst_ni = 1'b1;
         bus.dpPosEdgeSync_i = ($urandom_range(0, 99) < 8);
         bus.dpNegEdgeSync_i = ($urandom_range(0, 99) < 8);
         bus.dpplClear_i     = ($urandom_range(0, 99) < 2);
         bus.crcValid_i      = ($urandom_range(0, 99) < 70);
         bus.crcData_i       = 1'($urandom);
         if (pendMode) begin
            bus.useCRC16_i = ~bus.useCRC16_i;
            bus.crcReset_i = 1'b1;
            pendMode       = 0;
         end else if ($urandom_range(0, 99) < 1) begin
            bus.crcReset_i = 1'b1;
            pendMode       = 1;
         end else begin
            bus.crcReset_i = ($urandom_range(0, 99) < 3);
         end
         bus.bitStuffRst_i = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 99) < 1) bus.isSendingPhase_i = ~bus.isSendingPhase_i;
         bus.bitStuffData_i = ($urandom_range(0, 99) < 80);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/usb_bit_engine.md
Name: usb_bit_engine

Overview:
Bit-level core of the USB full-speed serial interface engine, shared by the RX and TX paths. It contains three functions, all in the 48 MHz domain:
- recovers the 12 MHz bit timing from the D+ edge pulses (4x oversampling DPLL);
- computes and checks CRC5/CRC16 serially;
- performs bit stuffing (TX) and bit unstuffing with error detection (RX).
CRC and stuffing logic advance only on the recovered bit strobe, so RX and TX share one timing base.

Parameters:
CRC5_RESIDUE, 5'b01100, CRC5 register value for a good packet.
CRC16_RESIDUE, 16'h800D, CRC16 register value for a good packet.
MAX_ONES, 6, consecutive ones before a stuff bit.

Ports:
clk48_i  in  1  48 MHz clock, the only clock
rst_ni  in  1  asynchronous active-low reset
dpplClear_i  in  1  synchronous clear of the DPLL (pulse on send-to-receive switch)
dpPosEdgeSync_i  in  1  one-cycle pulse, synchronized D+ rising edge
dpNegEdgeSync_i  in  1  one-cycle pulse, synchronized D+ falling edge
readCLK12_o  out  1  recovered 12 MHz bit clock (level)
bitStrobe_o  out  1  one-cycle pulse per bit period, aligned to the mid-bit sample point
DPPLGotSignal_o  out  1  an edge has been seen since the last clear
crcReset_i  in  1  synchronous CRC re-init
crcValid_i  in  1  crcData_i is a CRC-covered bit
useCRC16_i  in  1  1 selects CRC16, 0 selects CRC5
crcData_i  in  1  serial bit, LSB-first order
validCRC_o  out  1  register equals the selected residue
crc_o  out  16  CRC to transmit, inverted and reversed; bit 0 is sent first
bitStuffRst_i  in  1  synchronous clear of the stuffing logic
isSendingPhase_i  in  1  1 selects TX stuffing, 0 selects RX unstuffing
bitStuffData_i  in  1  bit in, NRZI-decoded
bitStuffReadyValid_o  out  1  TX: data bit consumed; RX: current bit is real data
bitStuffData_o  out  1  TX stuffed output bit
bitStuffError_o  out  1  RX stuff violation, sticky

Behaviour:
- Reset (rst_ni=0) values:
  - phase counter 0; readCLK12_o=0, bitStrobe_o=0, DPPLGotSignal_o=0;
  - CRC register all ones; ones counter 0; bitStuffError_o=0.
- DPLL:
  - 2-bit phase counter increments every clk48_i cycle.
  - An edge pulse (either polarity) loads the counter with 0 on the next edge.
  - bitStrobe_o=1 when counter==2, i.e. 2 cycles after an edge, then every 4 cycles.
  - readCLK12_o = counter[1], so its rise coincides with the strobe.
  - An edge arriving at any phase re-aligns the counter; with no edges it free-runs at 12 MHz.
  - DPPLGotSignal_o is set by the first edge pulse.
  - dpplClear_i zeroes the counter and DPPLGotSignal_o; an edge pulse in the same cycle still sets DPPLGotSignal_o.
- CRC:
  - Register updates only when bitStrobe_o && crcValid_i.
  - Shift-left form with feedback fb = crcData_i ^ reg[msb].
  - CRC5 uses poly 0x05 on reg[4:0]; CRC16 uses poly 0x8005 on reg[15:0].
  - crcReset_i loads all ones and overrides an update in the same cycle.
  - crc_o[i] = ~reg[W-1-i] for i<W, where W is 5 or 16; upper bits are 0 in CRC5 mode.
  - validCRC_o is combinational.
- Stuffing, all updates on bitStrobe_o only:
  - Ones counter counts consecutive 1s, saturating at MAX_ONES; a 0 resets it to 0.
  - TX, stuff slot (counter==6): bitStuffReadyValid_o=0, bitStuffData_o=0, counter cleared, bitStuffData_i must be held.
  - TX, otherwise: bitStuffReadyValid_o=1 and bitStuffData_o=bitStuffData_i, both combinational.
  - RX, counter==6: bitStuffReadyValid_o=0 and the bit is dropped; a 1 sets bitStuffError_o.
  - bitStuffRst_i clears the counter and the error and has priority.
  - A change of isSendingPhase_i does not clear state; the user issues bitStuffRst_i.
- The asynchronous reset overrides all synchronous clears.

Decomposition:
- Package usb_bit_engine_pkg: CRC5/CRC16 polynomials, init and residue constants, MAX_ONES.
- One sub-module, usb_bit_clk_recovery, holding the DPLL counter and got-signal flag.
- CRC and stuffing logic stay inline.

Test Plan:
- Edge pulses every 4 cycles → bitStrobe_o 2 cycles after each pulse, DPPLGotSignal_o=1 after the first; dpplClear_i → DPPLGotSignal_o=0.
- Edge shifted by 1 cycle → strobe re-aligns to edge+2 with no double strobe inside the period.
- After crcReset_i with no bits → crc_o=16'h0000 (CRC16) and 5'h00 (CRC5). Feed bytes 0x00 0x01 0x02 0x03 then the 16 crc_o bits → validCRC_o=1; flipping one bit → 0.
- CRC5: 11 token bits 0x7FF then 5 crc_o bits → validCRC_o=1.
- TX: input 1111111 → output 1111110 then 1, bitStuffReadyValid_o=0 on the 7th strobe.
- RX: 1111110 → stuff bit dropped, no error; 1111111 → bitStuffError_o=1 until bitStuffRst_i.
